// File: rtl/diagv2_ecall_uart_tx_if.sv
// Core-side status/report bundle for the ECALL UART reporter: the core drives the
// ECALL strobe and status code, and the reporter returns the UART line, halt and counters.
interface diagv2_ecall_uart_tx_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
);
  logic              ecall;
  logic [DATA_W-1:0] statusCode;
  logic              tx;
  logic              halt;
  logic              busy;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;

  modport master (
    output ecall, statusCode,
    input  tx, halt, busy, pass_count, fail_count
  );

  modport slave (
    input  ecall, statusCode,
    output tx, halt, busy, pass_count, fail_count
  );
endinterface

// File: rtl/diagv2_ecall_uart_tx.sv
// ECALL result reporter: captures the status code on an ECALL edge, halts the core and
// sends "P|F, hex hi, hex lo, CR, LF" over UART 8N1 while keeping saturating pass/fail counts.
module diagv2_ecall_uart_tx #(
  parameter int DATA_W       = 64,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 8
) (
  input logic                      clk,
  input logic                      reset,
  diagv2_ecall_uart_tx_if.slave    bus
);
  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r, next_state_s;
  logic [TMR_W-1:0]  timer_r, timer_nxt_s;
  logic [2:0]        bit_idx_r, bit_idx_nxt_s;
  logic [2:0]        byte_idx_r, byte_idx_nxt_s;
  logic [7:0]        code_r;
  logic              pass_r;
  logic              ecall_d_r;
  logic              tx_r, halt_r, busy_r;
  logic              tx_nxt_s, halt_nxt_s, busy_nxt_s;
  logic [7:0]        byte_nxt_s;
  logic [CNT_W-1:0]  pass_count_r, fail_count_r;
  logic              capture_s, pass_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] code,
                                            input logic pass);
    case (idx)
      3'd0:    return pass ? 8'h50 : 8'h46;
      3'd1:    return hex_ascii(code[7:4]);
      3'd2:    return hex_ascii(code[3:0]);
      3'd3:    return 8'h0D;
      3'd4:    return 8'h0A;
      default: return 8'hFF;
    endcase
  endfunction

  assign capture_s = (state_r == IDLE) && bus.ecall && !ecall_d_r;
  assign pass_s    = (bus.statusCode == {DATA_W{1'b0}});

  // State register, bit timer and frame indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= {TMR_W{1'b0}};
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      ecall_d_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      timer_r    <= timer_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      ecall_d_r  <= bus.ecall;
    end
  end

  // Next-state logic: each line state lasts exactly CLKS_PER_BIT cycles, bytes back-to-back.
  always_comb begin
    next_state_s   = state_r;
    timer_nxt_s    = timer_r;
    bit_idx_nxt_s  = bit_idx_r;
    byte_idx_nxt_s = byte_idx_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          next_state_s   = START;
          timer_nxt_s    = TMR_LOAD;
          bit_idx_nxt_s  = 3'd0;
          byte_idx_nxt_s = 3'd0;
        end else begin
          next_state_s = IDLE;
        end
      end
      START, DATA, STOP: begin
        if (timer_r != {TMR_W{1'b0}}) begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end else begin
          timer_nxt_s = TMR_LOAD;
          if (state_r == START) begin
            next_state_s  = DATA;
            bit_idx_nxt_s = 3'd0;
          end else if (state_r == DATA) begin
            if (bit_idx_r == 3'd7) next_state_s  = STOP;
            else                   bit_idx_nxt_s = bit_idx_r + 3'd1;
          end else if (byte_idx_r == 3'd4) begin
            next_state_s = DONE;
          end else begin
            next_state_s   = START;
            byte_idx_nxt_s = byte_idx_r + 3'd1;
          end
        end
      end
      DONE: begin
        // The core stays frozen until the harness drops ecall (core reset).
        if (!bus.ecall) next_state_s = IDLE;
        else            next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so tx changes on the same edge as state entry.
  always_comb begin
    byte_nxt_s = frame_byte(byte_idx_nxt_s, code_r, pass_r);
    tx_nxt_s   = 1'b1;
    halt_nxt_s = (next_state_s != IDLE);
    busy_nxt_s = 1'b0;
    case (next_state_s)
      START: begin
        tx_nxt_s   = 1'b0;
        busy_nxt_s = 1'b1;
      end
      DATA: begin
        tx_nxt_s   = byte_nxt_s[bit_idx_nxt_s];
        busy_nxt_s = 1'b1;
      end
      STOP: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b1;
      end
      default: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, captured code and saturating pass/fail counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_r         <= 1'b1;
      halt_r       <= 1'b0;
      busy_r       <= 1'b0;
      code_r       <= 8'h00;
      pass_r       <= 1'b0;
      pass_count_r <= {CNT_W{1'b0}};
      fail_count_r <= {CNT_W{1'b0}};
    end else begin
      tx_r   <= tx_nxt_s;
      halt_r <= halt_nxt_s;
      busy_r <= busy_nxt_s;
      if (capture_s) begin
        code_r <= bus.statusCode[7:0];
        pass_r <= pass_s;
        if (pass_s && (pass_count_r != {CNT_W{1'b1}}))
          pass_count_r <= pass_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!pass_s && (fail_count_r != {CNT_W{1'b1}}))
          fail_count_r <= fail_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.tx         = tx_r;
  assign bus.halt       = halt_r;
  assign bus.busy       = busy_r;
  assign bus.pass_count = pass_count_r;
  assign bus.fail_count = fail_count_r;
endmodule

// File: tb/tb_diagv2_ecall_uart_tx.sv
// Directed bench for the ECALL UART reporter: expected frame bytes are queued when an
// ECALL is driven and popped as a bench-side UART receiver decodes the tx line.
module tb_diagv2_ecall_uart_tx;
  localparam int DATA_W = 64;
  localparam int CPB    = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   start_cyc = 0;
  logic [7:0] sb[$];
  string hexchars = "0123456789ABCDEF";

  diagv2_ecall_uart_tx_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  diagv2_ecall_uart_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] code);
    sb.push_back((code == 64'd0) ? 8'h50 : 8'h46);
    sb.push_back(8'(hexchars[int'(code[7:4])]));
    sb.push_back(8'(hexchars[int'(code[3:0])]));
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  // Called at a negedge; leaves the bench at the negedge where the start bit is first seen.
  task automatic drive_ecall(input logic [63:0] code, input bit expect_frame);
    bus.statusCode = code;
    bus.ecall      = 1'b1;
    if (expect_frame) push_frame(code);
    @(negedge clk);
    check("halt_after_capture", {63'd0, bus.halt}, 64'd1);
    check("busy_after_capture", {63'd0, bus.busy}, 64'd1);
    start_cyc = cyc;
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok, output logic stop);
    ok = 1'b0;
    b = 8'hxx;
    stop = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = bus.tx;
      end
      repeat (CPB) @(negedge clk);
      stop = bus.tx;
    end
  endtask

  task automatic recv_frame();
    logic [7:0] b;
    logic [7:0] exp;
    logic stop;
    bit ok;
    for (int k = 0; k < 5; k++) begin
      recv_byte(b, ok, stop);
      check("start_bit_seen", {63'd0, ok}, 64'd1);
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 8'hxx;
      check("frame_byte", {56'd0, b}, {56'd0, exp});
      check("stop_bit", {63'd0, stop}, 64'd1);
    end
  endtask

  task automatic wait_done(input bit check_time);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("busy_fall_seen", {63'd0, seen}, 64'd1);
    if (check_time) begin
      check("busy_fall_cycles", 64'(cyc - start_cyc), 64'(50 * CPB));
      check("done_halt", {63'd0, bus.halt}, 64'd1);
      check("done_tx", {63'd0, bus.tx}, 64'd1);
    end
  endtask

  task automatic release_ecall();
    bus.ecall = 1'b0;
    @(negedge clk);
    check("halt_release", {63'd0, bus.halt}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int bad_tx;
    bus.ecall = 1'b0;
    bus.statusCode = 64'd0;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_tx", {63'd0, bus.tx}, 64'd1);
    check("idle_halt", {63'd0, bus.halt}, 64'd0);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    check("idle_pass", {56'd0, bus.pass_count}, 64'd0);
    check("idle_fail", {56'd0, bus.fail_count}, 64'd0);

    // 2: passing code
    drive_ecall(64'd0, 1'b1);
    recv_frame();
    wait_done(1'b1);
    check("pass_count_1", {56'd0, bus.pass_count}, 64'd1);
    check("fail_count_0", {56'd0, bus.fail_count}, 64'd0);
    release_ecall();

    // 3: failing code; mid-frame ecall re-edge and code change must be ignored
    drive_ecall(64'h2B, 1'b1);
    fork
      recv_frame();
      begin
        repeat (50) @(negedge clk);
        bus.ecall = 1'b0;
        bus.statusCode = 64'd0;
        @(negedge clk);
        bus.ecall = 1'b1;
      end
    join
    wait_done(1'b1);
    check("fail_count_1", {56'd0, bus.fail_count}, 64'd1);
    check("pass_unchanged", {56'd0, bus.pass_count}, 64'd1);
    release_ecall();

    // 4: nonzero only above the low byte
    drive_ecall(64'h1_0000_0000, 1'b1);
    recv_frame();
    wait_done(1'b1);
    check("fail_count_2", {56'd0, bus.fail_count}, 64'd2);

    // 5: ecall held in DONE never retriggers
    bad_tx = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad_tx++;
    end
    check("held_ecall_quiet", 64'(bad_tx), 64'd0);
    check("held_halt", {63'd0, bus.halt}, 64'd1);
    check("held_fail", {56'd0, bus.fail_count}, 64'd2);
    check("held_pass", {56'd0, bus.pass_count}, 64'd1);
    release_ecall();
    drive_ecall(64'hA0, 1'b1);
    recv_frame();
    wait_done(1'b1);
    check("fail_count_3", {56'd0, bus.fail_count}, 64'd3);
    release_ecall();

    // 6: async reset during DATA of byte 2 ('5' = 0x35, bit1 = 0)
    drive_ecall(64'h5, 1'b0);
    repeat (89) @(negedge clk);
    check("mid_frame_tx_low", {63'd0, bus.tx}, 64'd0);
    reset = 1'b1;
    #1;
    check("reset_tx", {63'd0, bus.tx}, 64'd1);
    check("reset_halt", {63'd0, bus.halt}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_pass", {56'd0, bus.pass_count}, 64'd0);
    check("reset_fail", {56'd0, bus.fail_count}, 64'd0);
    bus.ecall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    drive_ecall(64'h9F, 1'b1);
    recv_frame();
    wait_done(1'b1);
    check("post_reset_fail", {56'd0, bus.fail_count}, 64'd1);
    release_ecall();

    // saturation of pass_count
    for (int n = 1; n <= 256; n++) begin
      bus.statusCode = 64'd0;
      bus.ecall = 1'b1;
      @(negedge clk);
      wait_done(1'b0);
      bus.ecall = 1'b0;
      repeat (2) @(negedge clk);
      if (n == 255) check("pass_count_255", {56'd0, bus.pass_count}, 64'hFF);
    end
    check("pass_count_saturated", {56'd0, bus.pass_count}, 64'hFF);
    check("fail_after_sat", {56'd0, bus.fail_count}, 64'd1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
